motor_ramp_ctrl: RTL and testbench

Duty-cycle sequencer for the robot drive PWM generators. Accepts speed/direction commands over a valid/ready handshake. Slews the applied duty toward the target in fixed steps aligned to PWM period boundaries, and inserts a ramp-down plus dead time on direction reversal. Sits between the command/register interface and the 8-bit PWM generator, driving its `duty` input and the H-bridge direction line.

---
 rtl/motor_ctrl_pkg.sv | 36 +++
 rtl/pwm_period_tick.sv | 26 ++
 rtl/motor_ramp_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the drive duty sequencer: FSM state encoding,
// default timing parameters and the saturating ramp-step helper.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_BRAKE = 3'd2,
    ST_DEAD  = 3'd3,
    ST_ESTOP = 3'd4
  } state_t;

  localparam int unsigned DEF_PERIOD_CLKS = 256;
  localparam int unsigned DEF_RAMP_DIV    = 4;
  localparam int unsigned DEF_STEP        = 8;
  localparam int unsigned DEF_DEAD_TICKS  = 2;
  localparam int unsigned DEF_WDOG_TICKS  = 64;

  // One ramp step from cur toward tgt, computed in 9 bits so neither
  // direction can wrap; the result lands exactly on tgt instead of overshooting.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                           input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, cur} + {1'b0, step};
    dn = {1'b0, cur} - {1'b0, step};
    if (cur < tgt)
      ramp_step = (up > {1'b0, tgt}) ? tgt : up[7:0];
    else if (cur > tgt)
      ramp_step = (dn[8] || (dn[7:0] < tgt)) ? tgt : dn[7:0];
    else
      ramp_step = cur;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter. o_tick is high for the single clock in
// which the count sits at PERIOD_CLKS-1, i.e. once per PWM period.
module pwm_period_tick #(
  parameter int unsigned PERIOD_CLKS = 256
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CW = (PERIOD_CLKS > 2) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CLKS - 1);

  logic [CW-1:0] r_cnt;

  // Period counter wraps at PERIOD_CLKS-1.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty-cycle sequencer for the drive PWM: slews the applied duty toward the
// commanded target on PWM period boundaries, brakes to zero and waits a dead
// time before flipping direction, and forces zero duty on emergency stop.
// Optional command watchdog is built when MOTOR_RAMP_WDOG_EN is defined.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_CLKS = DEF_PERIOD_CLKS,
  parameter int unsigned RAMP_DIV    = DEF_RAMP_DIV,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned DEAD_TICKS  = DEF_DEAD_TICKS,
  parameter int unsigned WDOG_TICKS  = DEF_WDOG_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       cmd_dir,
  input  logic       estop,
  input  logic       fault_clr,
  output logic [7:0] duty,
  output logic       dir,
  output logic       busy,
  output logic       fault,
  output logic       wdog_to
);

  if (RAMP_DIV == 0 || DEAD_TICKS == 0 || WDOG_TICKS == 0 || STEP == 0 || STEP > 255)
  begin : g_param_check
    $error("motor_ramp_ctrl: illegal timing parameter");
  end

  localparam logic [7:0]  STEP8     = 8'(STEP);
  localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_TICKS - 1);

  state_t      r_state;
  logic [7:0]  r_duty;
  logic [7:0]  r_tgt;
  logic        r_dir;
  logic        r_tdir;
  logic        r_fault;
  logic [15:0] r_div;
  logic [15:0] r_dead;

  logic        w_tick;
  logic        w_accept;
  logic        w_step;
  logic        w_wdog_fire;
  logic [7:0]  w_ramp_duty;
  logic [7:0]  w_brake_duty;

  pwm_period_tick #(.PERIOD_CLKS(PERIOD_CLKS)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // estop drops ready combinationally so a same-cycle command is never taken.
  assign cmd_ready    = ((r_state == ST_IDLE) || (r_state == ST_RAMP)) && !estop;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_step       = w_tick && (r_div == DIV_LAST);
  assign w_ramp_duty  = ramp_step(r_duty, r_tgt, STEP8);
  assign w_brake_duty = ramp_step(r_duty, 8'd0, STEP8);

`ifdef MOTOR_RAMP_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_TICKS - 1);
  localparam logic [15:0] WDOG_FULL = 16'(WDOG_TICKS);

  logic [15:0] r_wdog_cnt;
  logic        r_wdog_to;

  // Fires once on the tick that completes WDOG_TICKS ticks without a command.
  assign w_wdog_fire = w_tick && (r_wdog_cnt == WDOG_LAST) && !w_accept &&
                       !estop && (r_state != ST_ESTOP);

  // Watchdog tick counter (saturating, frozen in ESTOP) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_to  <= 1'b0;
    end else begin
      if (w_accept)
        r_wdog_cnt <= '0;
      else if (w_tick && (r_state != ST_ESTOP) && (r_wdog_cnt != WDOG_FULL))
        r_wdog_cnt <= r_wdog_cnt + 16'd1;
      if (w_accept)         r_wdog_to <= 1'b0;
      else if (w_wdog_fire) r_wdog_to <= 1'b1;
    end
  end

  assign wdog_to = r_wdog_to;
`else
  assign w_wdog_fire = 1'b0;
  assign wdog_to     = 1'b0;
`endif

  // Sequencer FSM: command intake, tick-aligned ramp, brake, dead time, e-stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
      r_tdir  <= 1'b0;
      r_fault <= 1'b0;
      r_div   <= '0;
      r_dead  <= '0;
    end else if (estop) begin
      r_state <= ST_ESTOP;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_fault <= 1'b1;
      r_div   <= '0;
      r_dead  <= '0;
    end else begin
      // The divider only runs while the duty is slewing; later branches clear it.
      if (w_tick && ((r_state == ST_RAMP) || (r_state == ST_BRAKE)))
        r_div <= w_step ? '0 : r_div + 16'd1;

      unique case (r_state)
        ST_IDLE, ST_RAMP: begin
          if (w_accept) begin
            // A command edge only re-plans; duty moves on a later step.
            r_tgt  <= cmd_duty;
            r_tdir <= cmd_dir;
            if (cmd_dir == r_dir) begin
              if (cmd_duty != r_duty) begin
                r_state <= ST_RAMP;
              end else begin
                r_state <= ST_IDLE;
                r_div   <= '0;
              end
            end else if (r_duty == 8'd0) begin
              r_state <= ST_DEAD;
              r_div   <= '0;
              r_dead  <= '0;
            end else begin
              r_state <= ST_BRAKE;
            end
          end else if ((r_state == ST_RAMP) && w_step) begin
            r_duty <= w_ramp_duty;
            if (w_ramp_duty == r_tgt) begin
              r_state <= ST_IDLE;
              r_div   <= '0;
            end
          end
        end
        ST_BRAKE: begin
          if (w_step) begin
            r_duty <= w_brake_duty;
            if (w_brake_duty == 8'd0) begin
              r_state <= ST_DEAD;
              r_div   <= '0;
              r_dead  <= '0;
            end
          end
        end
        ST_DEAD: begin
          if (w_tick) begin
            if (r_dead == DEAD_LAST) begin
              r_dir   <= r_tdir;
              r_dead  <= '0;
              r_state <= (r_tgt != 8'd0) ? ST_RAMP : ST_IDLE;
            end else begin
              r_dead <= r_dead + 16'd1;
            end
          end
        end
        ST_ESTOP: begin
          if (fault_clr) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Watchdog timeout overrides the plan: wind the duty back down to zero.
      if (w_wdog_fire) begin
        r_tgt <= '0;
        if (r_duty != 8'd0) r_state <= ST_RAMP;
      end
    end
  end

  assign duty  = r_duty;
  assign dir   = r_dir;
  assign fault = r_fault;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl. Expected duty/dir/ready/busy per
// PWM tick are derived from the ramp/brake/dead-time rules with plain
// arithmetic into queues; the tick phase is tracked by the bench's own counter.
module tb_motor_ramp_ctrl;

  localparam int P   = 16;
  localparam int DIV = 1;
  localparam int STP = 8;
  localparam int DT  = 2;
  localparam int WD  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_duty = '0;
  logic       cmd_dir = 1'b0;
  logic       estop = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] duty;
  logic       dir;
  logic       busy;
  logic       fault;
  logic       wdog_to;

  motor_ramp_ctrl #(
    .PERIOD_CLKS(P), .RAMP_DIV(DIV), .STEP(STP), .DEAD_TICKS(DT), .WDOG_TICKS(WD)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .estop(estop), .fault_clr(fault_clr),
    .duty(duty), .dir(dir), .busy(busy), .fault(fault), .wdog_to(wdog_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side period phase: 0 right after every tick edge.
  int tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
  end

  // Reference model state and expected per-tick sequence.
  int m_duty = 0;
  int m_dir  = 0;
  int q_duty[$];
  int q_dir[$];
  int q_rdy[$];
  int q_busy[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int r, input int rdy, input int bsy);
    q_duty.push_back(d);
    q_dir.push_back(r);
    q_rdy.push_back(rdy);
    q_busy.push_back(bsy);
  endtask

  task automatic clear_q();
    q_duty.delete(); q_dir.delete(); q_rdy.delete(); q_busy.delete();
  endtask

  // Expected post-tick outputs after accepting command (tgt, tdir) at rest.
  task automatic plan(input int tgt, input int tdir);
    int d;
    d = m_duty;
    if (tdir != m_dir) begin
      while (d > 0) begin
        d = (d > STP) ? d - STP : 0;
        push(d, m_dir, 0, 1);
      end
      for (int k = 1; k <= DT; k++)
        push(0, (k == DT) ? tdir : m_dir, (k == DT) ? 1 : 0, (k == DT) ? int'(tgt > 0) : 1);
      m_dir = tdir;
    end
    while (d != tgt) begin
      if (d < tgt) d = (d + STP > tgt) ? tgt : d + STP;
      else         d = (d - STP < tgt) ? tgt : d - STP;
      push(d, m_dir, 1, int'(d != tgt));
    end
    m_duty = tgt;
  endtask

  task automatic next_tick();
    @(negedge clk);
    while (tb_cnt != 0) @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (q_duty.size() == 0) break;
      next_tick();
      chk({tag, ".duty"},  32'(duty),      32'(q_duty.pop_front()));
      chk({tag, ".dir"},   32'(dir),       32'(q_dir.pop_front()));
      chk({tag, ".ready"}, 32'(cmd_ready), 32'(q_rdy.pop_front()));
      chk({tag, ".busy"},  32'(busy),      32'(q_busy.pop_front()));
    end
  endtask

  task automatic send(input int d, input int r);
    @(negedge clk);
    chk("send.ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_duty  = 8'(d);
    cmd_dir   = r[0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".duty"},  32'(duty),      32'd0);
    chk({tag, ".dir"},   32'(dir),       32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
    chk({tag, ".fault"}, 32'(fault),     32'd0);
    chk({tag, ".wdog"},  32'(wdog_to),   32'd0);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int d, r, gap;

    // Reset state.
    #1;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("post_reset");

    // Ramp up 0 -> 64, dir 0.
    send(64, 0); plan(64, 0); run(q_duty.size(), "ramp_up");

    // Reversal 64/0 -> 32/1: brake, dead time, ramp up.
    send(32, 1); plan(32, 1); run(q_duty.size(), "reverse");

    // Back to zero in dir 1.
    send(0, 1); plan(0, 1); run(q_duty.size(), "to_zero");

    // E-stop mid-ramp at duty 40 with a competing command.
    send(80, 1); plan(80, 1); run(5, "pre_estop");
    clear_q();
    chk("estop.pre_duty", 32'(duty), 32'd40);
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd200; cmd_dir = 1'b0;
    #1;
    chk("estop.ready_comb", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("estop.duty",  32'(duty),  32'd0);
    chk("estop.fault", 32'(fault), 32'd1);
    chk("estop.dir",   32'(dir),   32'd1);
    chk("estop.busy",  32'(busy),  32'd1);
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    chk("estop.clr_ignored", 32'(fault), 32'd1);
    estop = 1'b0;
    @(negedge clk);
    chk("estop.ready_held", 32'(cmd_ready), 32'd0);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    chk("estop_exit.fault", 32'(fault),     32'd0);
    chk("estop_exit.busy",  32'(busy),      32'd0);
    chk("estop_exit.dir",   32'(dir),       32'd1);
    chk("estop_exit.duty",  32'(duty),      32'd0);
    chk("estop_exit.ready", 32'(cmd_ready), 32'd1);
    m_duty = 0; m_dir = 1;
    for (int i = 0; i < 2; i++) begin
      next_tick();
      chk("estop_cmd_dropped.duty", 32'(duty), 32'd0);
      chk("estop_cmd_dropped.busy", 32'(busy), 32'd0);
    end

    // Saturation: 60 lands exactly, then 255 with a mid-ramp retarget.
    send(60, 1); plan(60, 1); run(q_duty.size(), "sat60");
    send(255, 1); plan(255, 1); run(12, "sat255a");
    send(255, 1); run(q_duty.size(), "sat255b");
    chk("sat255.final", 32'(duty), 32'd255);

    // Asynchronous reset from full duty, dir 1.
    @(negedge clk); rst = 1'b1; #1;
    chk_reset_vals("rst_full");
    @(negedge clk); rst = 1'b0;
    m_duty = 0; m_dir = 0;

    // Reset mid-ramp at duty 24.
    send(48, 0); plan(48, 0); run(3, "pre_rst");
    clear_q();
    chk("rst_mid.pre_duty", 32'(duty), 32'd24);
    rst = 1'b1; #1;
    chk_reset_vals("rst_mid");
    @(negedge clk); rst = 1'b0;
    m_duty = 0; m_dir = 0;

    // Watchdog: command 48, then silence.
    send(48, 0); plan(48, 0); d = q_duty.size(); run(d, "wdog_ramp");
    for (int k = d + 1; k < WD; k++) begin
      next_tick();
      chk("wdog.quiet", 32'(wdog_to), 32'd0);
      chk("wdog.hold",  32'(duty),    32'd48);
    end
    next_tick();
`ifdef MOTOR_RAMP_WDOG_EN
    chk("wdog.fire", 32'(wdog_to), 32'd1);
    chk("wdog.busy", 32'(busy),    32'd1);
    chk("wdog.duty", 32'(duty),    32'd48);
    plan(0, 0); run(q_duty.size(), "wdog_down");
    chk("wdog.sticky", 32'(wdog_to), 32'd1);
    send(16, 0);
    chk("wdog.cleared", 32'(wdog_to), 32'd0);
`else
    chk("wdog.off", 32'(wdog_to), 32'd0);
    chk("wdog.off_duty", 32'(duty), 32'd48);
    send(16, 0);
`endif
    plan(16, 0); run(q_duty.size(), "after_wdog");

    // Randomised commands against the reference model.
    for (int n = 0; n < 12; n++) begin
      gap = $urandom_range(0, 1);
      for (int g = 0; g < gap; g++) begin
        next_tick();
        chk("rnd.idle_duty", 32'(duty), 32'(m_duty));
        chk("rnd.idle_busy", 32'(busy), 32'd0);
      end
      d = $urandom_range(0, 64);
      r = $urandom_range(0, 1);
      send(d, r); plan(d, r); run(q_duty.size(), "rnd");
      @(negedge clk);
      chk("rnd.end_duty", 32'(duty),    32'(m_duty));
      chk("rnd.end_dir",  32'(dir),     32'(m_dir));
      chk("rnd.end_busy", 32'(busy),    32'd0);
      chk("rnd.end_wdog", 32'(wdog_to), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
